ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
- REQ-001 SHALL have parameter INHIBIT_CYCLES, default 1250, the number of clk cycles the PS/2 clock line is held low before a frame (100 us at 12.5 MHz).
- REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 187500, the cycle budget for device clocking per phase (15 ms at 12.5 MHz).
- REQ-003 clk, input, 1: the single clock; all logic runs on the rising edge.
- REQ-004 reset, input, 1: synchronous, active-high.
- REQ-005 tx_data, input, 8: command byte to send.
- REQ-006 tx_req, input, 1: start request, sampled only in IDLE.
- REQ-007 tx_busy, output, 1: high in every state except IDLE.
- REQ-008 tx_done, output, 1: one-cycle pulse on successful frame.
- REQ-009 tx_error, output, 1: one-cycle pulse on timeout or missing ACK.
- REQ-010 ps2_clk_in / ps2_data_in, input, 1 each: raw PS/2 line levels.
- REQ-011 ps2_clk_out / ps2_data_out, output, 1 each: levels to drive.
- REQ-012 ps2_clk_dir / ps2_data_dir, output, 1 each: 1 = drive the line, 0 = release (high-Z).

Function
- REQ-013 SHALL pass ps2_clk_in and ps2_data_in through 2-flop synchronizers, then a 4-sample majority-stable filter on the clock.
- REQ-014 SHALL detect a falling edge when the filtered clock is 1 in the previous cycle and 0 in the current cycle.
- REQ-015 SHALL implement states IDLE, INHIBIT, START, BITS, ACK, WAIT_IDLE.
- REQ-016 IDLE: both dir=0; on tx_req, latch tx_data, compute odd parity (~^tx_data), load shift register {1 stop, parity, data[7:0]}, and go to INHIBIT.
- REQ-017 INHIBIT: clk_dir=1, clk_out=0 for INHIBIT_CYCLES; on the last cycle also set data_dir=1, data_out=0 (start bit); then go to START.
- REQ-018 START: clk_dir=0 and data held low; reset the timeout counter; on the first falling edge present data[0]; go to BITS.
- REQ-019 BITS: on each falling edge shift the next bit onto data_out (LSB first, then parity, then stop=1).
- REQ-020 BITS: after the falling edge that completes the stop bit (10th edge overall), set data_dir=0 and go to ACK.
- REQ-021 ACK: on the 11th falling edge, sample the synchronized data; 0 means ACK ok.
- REQ-022 WAIT_IDLE: wait until the filtered clock and data are both 1, then return to IDLE.
- REQ-023 WAIT_IDLE: pulse tx_done (ACK ok) or tx_error (NACK) in the same cycle as the return to IDLE.
- REQ-024 SHALL abort to IDLE with a tx_error pulse and both dir=0 if the timeout counter reaches TIMEOUT_CYCLES in START, BITS, ACK or WAIT_IDLE; the counter restarts on every falling edge.
- REQ-025 SHALL ignore tx_req when not in IDLE; tx_done and tx_error SHALL never be high together.
- REQ-026 Back-to-back: tx_req high in the cycle after tx_done SHALL start a new frame with no lost cycle.

Reset
- REQ-027 Reset SHALL force state IDLE; tx_busy, tx_done, tx_error, clk_dir and data_dir = 0; clk_out and data_out = 1; counters and shift register = 0.
- REQ-028 Reset mid-frame SHALL release both lines on the next clk edge and emit no tx_done or tx_error.

Configuration
- REQ-029 Macro PS2_TX_ACK_CHECK_EN defined: ACK sampling per REQ-021; a NACK yields tx_error.
- REQ-030 Macro PS2_TX_ACK_CHECK_EN undefined: the 11th edge is still awaited, its data value is ignored, and tx_done is always pulsed (tx_error only on timeout).

Verification
- REQ-031 Device model clocks at 10 kHz and ACKs; tx_data=0xF4 -> bits observed on rising edges are 0,0,0,1,0,1,1,1,1, parity 0, stop 1; one tx_done pulse.
- REQ-032 tx_data=0xFF with device ACK -> parity bit 1; tx_done pulse; clk held low at least 1250 cycles before release.
- REQ-033 Device never clocks after inhibit -> tx_error exactly 187500 cycles after entering START; both dir=0.
- REQ-034 Device returns data=1 on the 11th edge -> tx_error with PS2_TX_ACK_CHECK_EN defined; tx_done with it undefined.
- REQ-035 Reset asserted after the 5th falling edge -> next cycle both dir=0, tx_busy=0, no done or error pulse; next tx_req=0xAA completes normally.
- REQ-036 tx_req pulsed during BITS -> ignored and the frame is unchanged; tx_req held high across tx_done -> second frame starts in the next cycle.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter with line filtering and timeouts.
// Define PS2_TX_ACK_CHECK_EN to report a device NACK on tx_error instead of tx_done.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 1250,
    parameter int TIMEOUT_CYCLES = 187500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_req,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_out,
    output logic       ps2_data_out,
    output logic       ps2_clk_dir,
    output logic       ps2_data_dir
);
    localparam int MAXC = INHIBIT_CYCLES > TIMEOUT_CYCLES ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    typedef enum logic [2:0] {IDLE, INHIBIT, START, BITS, ACK, WAIT_IDLE} state_t;
    state_t state_q, state_d;
    logic [1:0] clk_sync_q, data_sync_q;
    logic [3:0] hist_q;
    logic fclk_q, fclk_d, fclk_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [9:0] shift_q, shift_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic ack_ok_q, ack_ok_d, done_q, done_d, error_q, error_d;
    logic fall, last_inh, timeout;

    assign fall     = fclk_prev_q & ~fclk_q;
    assign last_inh = cnt_q == CW'(INHIBIT_CYCLES - 1);
    assign timeout  = cnt_q == CW'(TIMEOUT_CYCLES - 1);
    assign tx_busy  = state_q != IDLE;
    assign tx_done  = done_q;
    assign tx_error = error_q;
    // filtered clock only moves once four consecutive samples agree
    assign fclk_d   = (&hist_q) ? 1'b1 : (~|hist_q) ? 1'b0 : fclk_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            hist_q      <= 4'hF;
            fclk_q      <= 1'b1;
            fclk_prev_q <= 1'b1;
            cnt_q       <= '0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            ack_ok_q    <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
            data_sync_q <= {data_sync_q[0], ps2_data_in};
            hist_q      <= {hist_q[2:0], clk_sync_q[1]};
            fclk_q      <= fclk_d;
            fclk_prev_q <= fclk_q;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            ack_ok_q    <= ack_ok_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        ack_ok_d  = ack_ok_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        case (state_q)
            IDLE: if (tx_req) begin
                state_d   = INHIBIT;
                cnt_d     = '0;
                shift_d   = {1'b1, ~^tx_data, tx_data};
                bit_cnt_d = '0;
            end
            INHIBIT: begin
                cnt_d = cnt_q + 1'b1;
                if (last_inh) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            default: begin
                cnt_d = cnt_q + 1'b1;
                if (fall) begin
                    cnt_d = '0;
                    case (state_q)
                        START: state_d = BITS;
                        BITS: begin
                            shift_d   = shift_q >> 1;
                            bit_cnt_d = bit_cnt_q + 1'b1;
                            if (bit_cnt_q == 4'd8) state_d = ACK;
                        end
                        ACK: begin
`ifdef PS2_TX_ACK_CHECK_EN
                            ack_ok_d = ~data_sync_q[1];
`else
                            ack_ok_d = 1'b1;
`endif
                            state_d = WAIT_IDLE;
                        end
                        default: ;
                    endcase
                end else if (timeout) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                end
                if (state_q == WAIT_IDLE && fclk_q && data_sync_q[1]) begin
                    state_d = IDLE;
                    done_d  = ack_ok_q;
                    error_d = ~ack_ok_q;
                end
            end
        endcase
    end

    // data is driven low for the start bit from the last inhibit cycle until the device clocks
    always_comb begin
        ps2_clk_dir  = state_q == INHIBIT;
        ps2_clk_out  = state_q != INHIBIT;
        ps2_data_dir = (state_q == INHIBIT && last_inh) || state_q == START || state_q == BITS;
        ps2_data_out = state_q == BITS ? shift_q[0] : ~ps2_data_dir;
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench for ps2_host_tx with a clocking PS/2 device model.
module tb_ps2_host_tx;
    localparam int INH  = 50;
    localparam int TMO  = 400;
    localparam int HALF = 30;
    localparam int LIM  = 5000;

    logic clk = 1'b0;
    logic reset, tx_req, tx_busy, tx_done, tx_error;
    logic [7:0] tx_data;
    logic ps2_clk_out, ps2_data_out, ps2_clk_dir, ps2_data_dir;
    logic dev_clk, dev_data, clk_line, data_line;
    int checks = 0;
    int passes = 0;
    int inh_run = 0;
    logic [1:0]  exp_res[$];
    logic [10:0] exp_frame[$];

    always #5 clk = ~clk;

    assign clk_line  = (ps2_clk_dir ? ps2_clk_out : 1'b1) & dev_clk;
    assign data_line = (ps2_data_dir ? ps2_data_out : 1'b1) & dev_data;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_req(tx_req),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error),
        .ps2_clk_in(clk_line), .ps2_data_in(data_line),
        .ps2_clk_out(ps2_clk_out), .ps2_data_out(ps2_data_out),
        .ps2_clk_dir(ps2_clk_dir), .ps2_data_dir(ps2_data_dir)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
        else passes++;
    endtask

    // result monitor: every done/error pulse must match the next queued outcome
    always @(negedge clk) begin
        logic [1:0] e;
        if (tx_done === 1'b1 || tx_error === 1'b1) begin
            e = 2'b00;
            if (exp_res.size() != 0) e = exp_res.pop_front();
            check("result", {tx_done, tx_error}, e);
        end
    end

    always @(negedge clk) begin
        if (ps2_clk_dir === 1'b1 && ps2_clk_out === 1'b0) inh_run++;
        else if (inh_run != 0) begin
            check("inhibit_len", inh_run, INH);
            inh_run = 0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic send(input logic [7:0] d);
        tx_data = d;
        tx_req  = 1'b1;
        @(negedge clk);
        tx_req  = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (tx_busy && n < LIM) begin @(negedge clk); n++; end
        check("wait_idle", n < LIM, 1);
        repeat (5) @(negedge clk);
    endtask

    task automatic device_frame(input int n_edges, input bit ack_bit, input int poke);
        logic [10:0] got;
        logic [10:0] e;
        int n = 0;
        got = '0;
        while (!(ps2_clk_dir === 1'b1 && ps2_clk_out === 1'b0) && n < LIM) begin @(negedge clk); n++; end
        while (!(ps2_clk_dir === 1'b0 && data_line === 1'b0) && n < LIM) begin @(negedge clk); n++; end
        check("dev_release_wait", n < LIM, 1);
        got[0] = data_line;
        repeat (5) @(negedge clk);
        for (int k = 1; k <= n_edges; k++) begin
            if (k == 11) begin dev_data = ack_bit; repeat (5) @(negedge clk); end
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            if (k == poke) begin
                tx_data = 8'h00;
                tx_req  = 1'b1;
                @(negedge clk);
                tx_req  = 1'b0;
            end
            dev_clk = 1'b1;
            if (k <= 10) got[k] = data_line;
            repeat (HALF) @(negedge clk);
        end
        dev_data = 1'b1;
        if (n_edges == 11) begin
            e = 11'h7FF;
            if (exp_frame.size() != 0) e = exp_frame.pop_front();
            check("frame_bits", got, e);
        end
    endtask

    task automatic frame(input logic [7:0] d, input logic [10:0] bits, input logic [1:0] res,
                         input bit ack_bit, input int poke);
        exp_res.push_back(res);
        exp_frame.push_back(bits);
        send(d);
        device_frame(11, ack_bit, poke);
        wait_idle();
    endtask

    initial begin
        int n;
        reset = 1'b1; tx_req = 1'b0; tx_data = 8'h00; dev_clk = 1'b1; dev_data = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_state", {tx_busy, tx_done, tx_error, ps2_clk_dir, ps2_data_dir, ps2_clk_out, ps2_data_out}, 7'b0000011);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        // frames as {stop, parity, data[7:0], start}
        frame(8'hF4, 11'b1_0_11110100_0, 2'b10, 1'b0, 0);
        frame(8'hFF, 11'b1_1_11111111_0, 2'b10, 1'b0, 0);
        // device stays silent after inhibit
        exp_res.push_back(2'b01);
        send(8'h12);
        n = 0;
        while (ps2_clk_dir !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
        while (ps2_clk_dir === 1'b1 && n < LIM) begin @(negedge clk); n++; end
        n = 0;
        while (tx_error !== 1'b1 && n < TMO + 50) begin @(negedge clk); n++; end
        check("timeout_cycles", n, TMO);
        check("timeout_lines", {ps2_clk_dir, ps2_data_dir, tx_busy, tx_done}, 4'b0000);
        wait_idle();
`ifdef PS2_TX_ACK_CHECK_EN
        frame(8'h81, 11'b1_1_10000001_0, 2'b01, 1'b1, 0);
`else
        frame(8'h81, 11'b1_1_10000001_0, 2'b10, 1'b1, 0);
`endif
        // reset after the 5th falling edge, then a clean frame
        send(8'h66);
        device_frame(5, 1'b0, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("reset_mid_frame", {ps2_clk_dir, ps2_data_dir, tx_busy, tx_done, tx_error}, 5'b00000);
        repeat (20) @(negedge clk);
        frame(8'hAA, 11'b1_1_10101010_0, 2'b10, 1'b0, 0);
        frame(8'h3C, 11'b1_1_00111100_0, 2'b10, 1'b0, 4);
        // tx_req held high across tx_done
        exp_res.push_back(2'b10); exp_res.push_back(2'b10);
        exp_frame.push_back(11'b1_1_01011010_0); exp_frame.push_back(11'b1_1_01011010_0);
        tx_data = 8'h5A;
        tx_req  = 1'b1;
        device_frame(11, 1'b0, 0);
        n = 0;
        while (tx_done !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
        check("b2b_done", tx_done, 1);
        check("b2b_idle_at_done", tx_busy, 0);
        @(negedge clk);
        tx_req = 1'b0;
        check("b2b_restart", {tx_busy, ps2_clk_dir}, 2'b11);
        device_frame(11, 1'b0, 0);
        wait_idle();
        check("res_queue_empty", exp_res.size(), 0);
        check("frame_queue_empty", exp_frame.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
